serial_subtractor: RTL and testbench

Parametrised, multi-cycle N-bit subtractor built from a chained half/full-subtract stage. It computes diff = a - b - bin over WIDTH/CHUNK clock cycles, processing CHUNK bits per cycle LSB-first and carrying the borrow between cycles. A start/busy/done handshake lets it sit beside other arithmetic blocks as a low-area alternative to a flat ripple subtractor.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Port ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, borrow);
  modport slave  (input start, a, b, bin, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB first.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw_q;
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic [CHUNK:0]   sub_ext;
  logic [CHUNK-1:0] dchunk;
  logic             bout;
  logic [WIDTH-1:0] res_next;
  logic             last;

  always_comb begin
    sub_ext  = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw_q};
    dchunk   = sub_ext[CHUNK-1:0];
    bout     = sub_ext[CHUNK];
    // New chunk enters at the MSB end; after N shifts the LSB chunk sits at bit 0.
    res_next = WIDTH'({dchunk, res_q} >> CHUNK);
    last     = (cnt_q == CntW'(N - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  logic ovf_next;

  // Borrow into the top bit is recovered from that bit's own sum: a ^ b ^ bin = d.
  always_comb begin
    ovf_next = (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ dchunk[CHUNK-1]) ^ bout;
  end

  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            brw_q   <= bus.bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          brw_q <= bout;
          res_q <= res_next;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_next;
            borrow_q <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_next;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor with CHUNK = 1, 4 and 8 (WIDTH = 8) against an arithmetic model.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_subtractor_if #(.WIDTH(8)) ifc1 ();
  serial_subtractor_if #(.WIDTH(8)) ifc4 ();
  serial_subtractor_if #(.WIDTH(8)) ifc8 ();

  serial_subtractor #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  serial_subtractor #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));
  serial_subtractor #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .bus(ifc8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 9-bit unsigned and integer signed arithmetic.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                output logic [7:0] d, output logic br, output logic ov);
    logic [8:0] r9;
    int         s;
    r9 = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    d  = r9[7:0];
    br = r9[8];
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov = (s < -128) || (s > 127);
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    case (sel)
      1: begin ifc1.start = st; ifc1.a = a; ifc1.b = b; ifc1.bin = bin; end
      4: begin ifc4.start = st; ifc4.a = a; ifc4.b = b; ifc4.bin = bin; end
      default: begin ifc8.start = st; ifc8.a = a; ifc8.b = b; ifc8.bin = bin; end
    endcase
  endtask

  task automatic get_out(input int sel, output logic bsy, output logic dn, output logic [7:0] d,
                         output logic br, output logic ov);
    ov = 1'b0;
    case (sel)
      1: begin
        bsy = ifc1.busy; dn = ifc1.done; d = ifc1.diff; br = ifc1.borrow;
`ifdef SERIAL_SUB_OVF_EN
        ov = ifc1.ovf;
`endif
      end
      4: begin
        bsy = ifc4.busy; dn = ifc4.done; d = ifc4.diff; br = ifc4.borrow;
`ifdef SERIAL_SUB_OVF_EN
        ov = ifc4.ovf;
`endif
      end
      default: begin
        bsy = ifc8.busy; dn = ifc8.done; d = ifc8.diff; br = ifc8.borrow;
`ifdef SERIAL_SUB_OVF_EN
        ov = ifc8.ovf;
`endif
      end
    endcase
  endtask

  // Start one operation and wait (bounded) for done; lat = edges after the accepting edge.
  task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic bsy0, output logic [7:0] d, output logic br, output logic ov,
                       output int lat);
    logic bsy, dn;
    set_in(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    get_out(sel, bsy0, dn, d, br, ov);
    lat = 0;
    while (!dn && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      get_out(sel, bsy, dn, d, br, ov);
    end
  endtask

  task automatic test_reset();
    logic bsy, dn, br, ov;
    logic [7:0] d;
    for (int s = 1; s <= 8; s = s * 2) begin
      if (s == 2) continue;
      get_out(s, bsy, dn, d, br, ov);
      n_checks++;
      if ({bsy, dn, d, br, ov} !== 12'h0)
        $display("FAIL reset_outputs chunk=%0d got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                 s, bsy, dn, d, br, ov);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic bsy0, br, ov;
    logic [7:0] d;
    int lat;
    do_op(1, 8'h05, 8'h03, 1'b0, bsy0, d, br, ov, lat);
    n_checks++;
    if (bsy0 !== 1'b1) $display("FAIL busy_after_accept got %b want 1", bsy0); else n_pass++;
    n_checks++;
    if (lat != 8) $display("FAIL latency_chunk1 got %0d want 8", lat); else n_pass++;
    n_checks++;
    if ({d, br} !== {8'h02, 1'b0}) $display("FAIL sub_05_03 got %h/%b want 02/0", d, br);
    else n_pass++;
    do_op(1, 8'h03, 8'h05, 1'b0, bsy0, d, br, ov, lat);
    n_checks++;
    if ({d, br} !== {8'hFE, 1'b1}) $display("FAIL sub_03_05 got %h/%b want fe/1", d, br);
    else n_pass++;
    do_op(1, 8'h00, 8'h00, 1'b1, bsy0, d, br, ov, lat);
    n_checks++;
    if ({d, br} !== {8'hFF, 1'b1}) $display("FAIL sub_00_00_bin got %h/%b want ff/1", d, br);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic bsy0, bsy, dn, br, ov;
    logic [7:0] d;
    int lat;
    do_op(4, 8'hA5, 8'h5A, 1'b0, bsy0, d, br, ov, lat);
    n_checks++;
    if (lat != 2) $display("FAIL latency_chunk4 got %0d want 2", lat); else n_pass++;
    n_checks++;
    if ({d, br} !== {8'h4B, 1'b0}) $display("FAIL sub_a5_5a got %h/%b want 4b/0", d, br);
    else n_pass++;
    set_in(4, 1'b1, 8'h10, 8'h01, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0);
    get_out(4, bsy, dn, d, br, ov);
    n_checks++;
    if ({bsy, dn} !== 2'b10) $display("FAIL b2b_accept got busy=%b done=%b want 1/0", bsy, dn);
    else n_pass++;
    lat = 0;
    while (!dn && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      get_out(4, bsy, dn, d, br, ov);
    end
    n_checks++;
    if (lat != 2 || d !== 8'h0F || br !== 1'b0)
      $display("FAIL b2b_second got lat=%0d diff=%h borrow=%b want 2/0f/0", lat, d, br);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic bsy, dn, br, ov;
    logic [7:0] d;
    int lat;
    bit held;
    // Previous result from test_basic is ff/1.
    set_in(1, 1'b1, 8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    held = 1'b1;
    dn   = 1'b0;
    lat  = 0;
    while (!dn && lat < 64) begin
      if (lat == 3) set_in(1, 1'b1, 8'hFF, 8'h00, 1'b0);
      if (lat == 5) set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
      lat++;
      get_out(1, bsy, dn, d, br, ov);
      if (!dn && (d !== 8'hFF || br !== 1'b1)) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL hold_during_run got change want ff/1 held"); else n_pass++;
    n_checks++;
    if (lat != 8 || d !== 8'h02 || br !== 1'b0)
      $display("FAIL ignore_start got lat=%0d diff=%h borrow=%b want 8/02/0", lat, d, br);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    get_out(1, bsy, dn, d, br, ov);
    n_checks++;
    if ({bsy, dn, d} !== {2'b00, 8'h02})
      $display("FAIL hold_after_done got busy=%b done=%b diff=%h want 0/0/02", bsy, dn, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic bsy0, bsy, dn, br, ov;
    logic [7:0] d;
    int lat, dones;
    set_in(1, 1'b1, 8'h03, 8'h05, 1'b0);
    @(posedge clk); #1;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    get_out(1, bsy, dn, d, br, ov);
    n_checks++;
    if ({bsy, dn, d, br, ov} !== 12'h0)
      $display("FAIL async_reset got busy=%b done=%b diff=%h borrow=%b want all 0", bsy, dn, d, br);
    else n_pass++;
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      get_out(1, bsy, dn, d, br, ov);
      if (dn || bsy) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL no_done_after_abort got %0d active cycles want 0", dones);
    else n_pass++;
    do_op(1, 8'h40, 8'h11, 1'b1, bsy0, d, br, ov, lat);
    n_checks++;
    if (lat != 8 || d !== 8'h2E || br !== 1'b0)
      $display("FAIL fresh_after_reset got lat=%0d diff=%h borrow=%b want 8/2e/0", lat, d, br);
    else n_pass++;
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic bsy0, br, ov;
    logic [7:0] d;
    int lat;
    do_op(1, 8'h80, 8'h01, 1'b0, bsy0, d, br, ov, lat);
    n_checks++;
    if ({d, br, ov} !== {8'h7F, 1'b0, 1'b1})
      $display("FAIL ovf_80_01 got %h/%b/%b want 7f/0/1", d, br, ov);
    else n_pass++;
    do_op(1, 8'h00, 8'h7F, 1'b1, bsy0, d, br, ov, lat);
    n_checks++;
    if ({d, br, ov} !== {8'h80, 1'b1, 1'b0})
      $display("FAIL ovf_00_7f got %h/%b/%b want 80/1/0", d, br, ov);
    else n_pass++;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_random();
    logic bsy0, br, ov, ebr, eov;
    logic [7:0] a, b, d, ed;
    logic bin;
    int lat;
    for (int s = 1; s <= 8; s = s * 2) begin
      if (s == 2) continue;
      for (int i = 0; i < 30; i++) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        bin = 1'($urandom);
        model(a, b, bin, ed, ebr, eov);
        do_op(s, a, b, bin, bsy0, d, br, ov, lat);
        n_checks++;
        if (lat != 8 / s || d !== ed || br !== ebr
`ifdef SERIAL_SUB_OVF_EN
            || ov !== eov
`endif
           )
          $display("FAIL random chunk=%0d %h-%h-%b got lat=%0d %h/%b/%b want %0d %h/%b/%b",
                   s, a, b, bin, lat, d, br, ov, 8 / s, ed, ebr, eov);
        else n_pass++;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
